// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the byte-lane mask that each access size selects.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Lanes touched by an access starting at offset 0.
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Stores have no unsigned variants, so only b/h/w are legal for them.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic legal;
        if (we) begin
            legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW);
        end else begin
            legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                    (funct3 == LBU) || (funct3 == LHU);
        end
        return legal;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns the loaded bytes from a (possibly two-word) fetch down to bit 0 and
// sign- or zero-extends them to a full word.
module load_extend
    import lsu_pkg::*;
(
    input  logic [55:0] pair,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    // Only the low 24 bits of the high word can ever be reached (offset 3 + word).
    logic [31:0] window_opts [4];
    logic [31:0] window;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_window
            assign window_opts[gi] = pair[8*gi +: 32];
        end
    endgenerate

    assign window = window_opts[off];

    always_comb begin
        result = window;
        case (funct3[1:0])
            2'b00:   result = {{24{window[7]  & ~funct3[2]}}, window[7:0]};
            2'b01:   result = {{16{window[15] & ~funct3[2]}}, window[15:0]};
            default: result = window;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Pipeline-side load/store initiator: one access at a time onto a word-wide,
// byte-strobed req/ack memory port, splitting word-crossing accesses in two.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     fault,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_t                 state_reg;
    logic                       we_reg;
    logic [2:0]                 funct3_reg;
    logic [ADDRESS_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]      wdata_reg;
    logic                       fault_reg;
    logic [DATA_WIDTH-1:0]      lo_reg;
    logic [23:0]                hi_reg;
    logic [DATA_WIDTH-1:0]      rdata_reg;

    logic [1:0]                 off;
    logic [7:0]                 mask8;
    logic [2*DATA_WIDTH-1:0]    data64;
    logic                       split;
    logic [ADDRESS_WIDTH-1:0]   word_addr;
    logic [ADDRESS_WIDTH-1:0]   next_addr;
    logic                       in_acc0;
    logic                       in_acc1;
    logic                       ack_taken;
    logic [DATA_WIDTH-1:0]      ext_lo;
    logic [23:0]                ext_hi;
    logic [DATA_WIDTH-1:0]      ext_result;

    assign off       = addr_reg[1:0];
    assign mask8     = {4'b0000, byte_mask(funct3_reg)} << off;
    assign data64    = {{DATA_WIDTH{1'b0}}, wdata_reg} << {off, 3'b000};
    assign split     = |mask8[7:4];
    assign word_addr = {addr_reg[ADDRESS_WIDTH-1:2], 2'b00};
    assign next_addr = word_addr + ADDRESS_WIDTH'(4);

    assign in_acc0   = (state_reg == ST_ACC0);
    assign in_acc1   = (state_reg == ST_ACC1);
    assign ack_taken = (in_acc0 || in_acc1) && mem_ack;

    // Memory port is decoded purely from registered state.
    assign mem_req   = in_acc0 || in_acc1;
    assign mem_we    = mem_req && we_reg;
    assign mem_addr  = in_acc0 ? word_addr : (in_acc1 ? next_addr : '0);
    assign mem_wdata = in_acc0 ? data64[DATA_WIDTH-1:0]
                     : (in_acc1 ? data64[2*DATA_WIDTH-1:DATA_WIDTH] : '0);
    assign mem_wstrb = !we_reg ? 4'b0000
                     : (in_acc0 ? mask8[3:0] : (in_acc1 ? mask8[7:4] : 4'b0000));

    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_DONE);
    assign fault = done && fault_reg;
    assign rdata = rdata_reg;

    // The finishing word arrives on mem_rdata in the ack cycle, so bypass it in.
    assign ext_lo = in_acc0 ? mem_rdata : lo_reg;
    assign ext_hi = in_acc1 ? mem_rdata[23:0] : hi_reg;

    load_extend u_load_extend (
        .pair   ({ext_hi, ext_lo}),
        .off    (off),
        .funct3 (funct3_reg),
        .result (ext_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            fault_reg  <= 1'b0;
            lo_reg     <= '0;
            hi_reg     <= '0;
            rdata_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        if (funct3_legal(req_we, req_funct3)) begin
                            fault_reg <= 1'b0;
                            state_reg <= ST_ACC0;
                        end else begin
                            fault_reg <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_ACC0: begin
                    if (ack_taken) begin
                        lo_reg <= mem_rdata;
                        if (split) begin
                            state_reg <= ST_ACC1;
                        end else begin
                            state_reg <= ST_DONE;
                            if (!we_reg) begin
                                rdata_reg <= ext_result;
                            end
                        end
                    end
                end
                ST_ACC1: begin
                    if (ack_taken) begin
                        hi_reg    <= mem_rdata[23:0];
                        state_reg <= ST_DONE;
                        if (!we_reg) begin
                            rdata_reg <= ext_result;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected memory beats and
// completions into queues; a negedge monitor plays memory and checks both.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rd;
    } mem_exp_t;

    typedef struct {
        string       name;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
    } done_exp_t;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    mem_exp_t  mon_m;
    done_exp_t mon_d;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int waits = 0;
    int wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder plus completion monitor.
    always @(negedge clk) begin
        cyc++;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt < waits) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (mem_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_mem_req: got req at %h, expected none", mem_addr);
                end else begin
                    mon_m = mem_q.pop_front();
                    check("mem_we",    {31'b0, mem_we}, {31'b0, mon_m.we});
                    check("mem_addr",  mem_addr,  mon_m.addr);
                    check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, mon_m.strb});
                    check("mem_wdata", mem_wdata, mon_m.wdata);
                    $display("mem beat we=%0b addr=%h strb=%b wdata=%h rd=%h",
                             mem_we, mem_addr, mem_wstrb, mem_wdata, mon_m.rd);
                    mem_rdata = mon_m.rd;
                    mem_ack   = 1'b1;
                end
            end
        end else begin
            wait_cnt = 0;
        end
        if (done) begin
            if (done_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done, expected none");
            end else begin
                mon_d = done_q.pop_front();
                check({mon_d.name, "_fault"}, {31'b0, fault}, {31'b0, mon_d.fault});
                check({mon_d.name, "_rdata"}, rdata, mon_d.rdata);
                check({mon_d.name, "_latency"}, 32'(cyc - accept_cyc), 32'(mon_d.lat));
                $display("done %s fault=%0b rdata=%h latency=%0d", mon_d.name, fault, rdata,
                         cyc - accept_cyc);
            end
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, input logic [31:0] rd);
        mem_exp_t m;
        m.we = we; m.addr = addr; m.strb = strb; m.wdata = wdata; m.rd = rd;
        mem_q.push_back(m);
    endtask

    // Holds req_valid through the whole access so a busy-time re-accept would show up.
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_fault, input logic [31:0] exp_rd, input int lat);
        done_exp_t d;
        bit ok;
        d.name = name; d.fault = exp_fault; d.rdata = exp_rd; d.lat = lat;
        done_q.push_back(d);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        check({name, "_busy"}, {31'b0, busy}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done in 60 cycles, expected done", name);
            done_q.delete();
            mem_q.delete();
        end else begin
            check({name, "_idle"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        #3;
        check("rst_busy",  {31'b0, busy},    32'd0);
        check("rst_done",  {31'b0, done},    32'd0);
        check("rst_fault", {31'b0, fault},   32'd0);
        check("rst_rdata", rdata,            32'd0);
        check("rst_req",   {31'b0, mem_req}, 32'd0);
        check("rst_we",    {31'b0, mem_we},  32'd0);
        check("rst_addr",  mem_addr,         32'd0);
        check("rst_wdata", mem_wdata,        32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        push_mem(1'b0, 32'h0000_0100, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        issue("lw_aligned", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);

        push_mem(1'b0, 32'h0000_0100, 4'b0000, 32'h0, 32'h80FF_FF00);
        issue("lb_neg", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b0, 32'hFFFF_FF80, 2);
        push_mem(1'b0, 32'h0000_0100, 4'b0000, 32'h0, 32'h80FF_FF00);
        issue("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1'b0, 32'h0000_0080, 2);

        push_mem(1'b1, 32'h0000_0100, 4'b1100, 32'hABCD_0000, 32'h0);
        issue("sh_hi", 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 1'b0, 32'h0000_0080, 2);

        push_mem(1'b1, 32'h0000_00FC, 4'b1100, 32'h3344_0000, 32'h0);
        push_mem(1'b1, 32'h0000_0100, 4'b0011, 32'h0000_1122, 32'h0);
        issue("sw_split", 1'b1, 3'b010, 32'h0000_00FE, 32'h1122_3344, 1'b0, 32'h0000_0080, 3);

        push_mem(1'b0, 32'h0000_00FC, 4'b0000, 32'h0, 32'hAA00_0000);
        push_mem(1'b0, 32'h0000_0100, 4'b0000, 32'h0, 32'h0000_0080);
        issue("lh_split", 1'b0, 3'b001, 32'h0000_00FF, 32'h0, 1'b0, 32'hFFFF_80AA, 3);
        push_mem(1'b0, 32'h0000_00FC, 4'b0000, 32'h0, 32'hAA00_0000);
        push_mem(1'b0, 32'h0000_0100, 4'b0000, 32'h0, 32'h0000_0080);
        issue("lhu_split", 1'b0, 3'b101, 32'h0000_00FF, 32'h0, 1'b0, 32'h0000_80AA, 3);

        push_mem(1'b0, 32'hFFFF_FFFC, 4'b0000, 32'h0, 32'h1234_5678);
        push_mem(1'b0, 32'h0000_0000, 4'b0000, 32'h0, 32'h9ABC_DEF0);
        issue("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'hDEF0_1234, 3);

        issue("ill_ld_011", 1'b0, 3'b011, 32'h0000_0100, 32'h0, 1'b1, 32'hDEF0_1234, 1);
        issue("ill_st_100", 1'b1, 3'b100, 32'h0000_0100, 32'h55, 1'b1, 32'hDEF0_1234, 1);
        issue("ill_ld_111", 1'b0, 3'b111, 32'h0000_0104, 32'h0, 1'b1, 32'hDEF0_1234, 1);

        waits = 2;
        push_mem(1'b0, 32'h0000_0200, 4'b0000, 32'h0, 32'h0102_0304);
        issue("lw_wait2", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b0, 32'h0102_0304, 4);
        waits = 0;

        push_mem(1'b0, 32'h0000_0200, 4'b0000, 32'h0, 32'h0000_7F00);
        issue("lb_pos", 1'b0, 3'b000, 32'h0000_0201, 32'h0, 1'b0, 32'h0000_007F, 2);
        push_mem(1'b0, 32'h0000_0204, 4'b0000, 32'h0, 32'h0000_8001);
        issue("lh_off0", 1'b0, 3'b001, 32'h0000_0204, 32'h0, 1'b0, 32'hFFFF_8001, 2);
        push_mem(1'b0, 32'h0000_0200, 4'b0000, 32'h0, 32'hBEEF_1234);
        issue("lhu_off2", 1'b0, 3'b101, 32'h0000_0202, 32'h0, 1'b0, 32'h0000_BEEF, 2);
        push_mem(1'b1, 32'h0000_0000, 4'b0010, 32'h0000_5A00, 32'h0);
        issue("sb_off1", 1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 1'b0, 32'h0000_BEEF, 2);

        waits = 1;
        push_mem(1'b1, 32'h0000_0100, 4'b1000, 32'hFE00_0000, 32'h0);
        push_mem(1'b1, 32'h0000_0104, 4'b0001, 32'h0000_00CA, 32'h0);
        issue("sh_split_wait", 1'b1, 3'b001, 32'h0000_0103, 32'h0000_CAFE, 1'b0, 32'h0000_BEEF, 5);

        // Reset while the memory withholds ack: access must vanish without a done.
        waits = 1000;
        push_mem(1'b0, 32'h0000_0300, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        check("abort_req_before", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_req",  {31'b0, mem_req}, 32'd0);
        check("abort_busy", {31'b0, busy},    32'd0);
        check("abort_done", {31'b0, done},    32'd0);
        check("abort_rdata", rdata,           32'd0);
        mem_q.delete();
        waits = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_idle", {31'b0, busy}, 32'd0);

        push_mem(1'b0, 32'h0000_0100, 4'b0000, 32'h0, 32'h0BAD_F00D);
        issue("lw_after_rst", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0, 32'h0BAD_F00D, 2);

        if (mem_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover_mem: got %0d unissued beats, expected 0", mem_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
